// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Used by the TX engine and top.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int FRAME_BITS = 8;
  localparam int OSR_DEF    = 16;

endpackage

// File: rtl/uart_fifo.sv
// Generic UART byte FIFO.
// Show-ahead head data, occupancy level.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   lvl,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Power-of-two depth lets the pointers wrap on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (lvl == '0);
  assign full  = (lvl == LW'(DEPTH));

endmodule

// File: rtl/uart_reg_macros.sv
// UART register map addresses.
// Shared by the UART register decode paths.
`ifndef UART_REG_MACROS_SV
`define UART_REG_MACROS_SV

`define UART_TX_DATA_ADDR 5'h04

`endif

// File: rtl/uart_tx_engine.sv
// UART TX framing engine: 8N1, LSB first.
// Bits are timed in oversample ticks.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       en,
  input  logic       empty,
  input  logic [7:0] head,
  output logic       pop,
  output logic       line,
  output logic       busy
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [2:0] IDX_LAST = 3'(FRAME_BITS - 1);

  tx_state_t      state;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shift;
  logic           ready;
  logic           bit_end;

  assign ready   = en && !empty;
  assign bit_end = tick && (cnt == LAST);

  // STOP chains straight into START when more data waits.
  assign pop = ready &&
               ((state == IDLE) ||
                ((state == STOP) && bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      line  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      if ((state != IDLE) && tick)
        cnt <= bit_end ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (ready) begin
            state <= START;
            shift <= head;
            line  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
            line  <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx == IDX_LAST) begin
              state <= STOP;
              line  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              shift <= shift >> 1;
              line  <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (ready) begin
              state <= START;
              shift <= head;
              line  <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit path: TX_DATA FIFO feeding
// the framing engine, plus overrun status.
`include "uart_reg_macros.sv"

module uart_tx
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OSR   = OSR_DEF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     osr_tick_i,
  input  logic                     tx_en_i,
  input  logic                     tx_clr_ovrn_i,
  input  logic                     reg_wen_i,
  input  logic [4:0]               reg_waddr_i,
  input  logic [7:0]               reg_wdata_i,
  output logic                     tx_data_o,
  output logic                     tx_busy_o,
  output logic                     tx_ovrn_o,
  output logic [$clog2(DEPTH):0]   tx_lvl_o,
  output logic                     tx_empty_o,
  output logic                     tx_full_o
);

  logic [1:0] rst_sync;
  logic       rst_n;
  logic       wr;
  logic       push;
  logic       pop;
  logic       ovf;
  logic [7:0] head;

  // Assert immediately, release on the clock.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign wr   = reg_wen_i &&
                (reg_waddr_i == `UART_TX_DATA_ADDR);
  assign push = wr && (!tx_full_o || pop);
  assign ovf  = wr && tx_full_o && !pop;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)             tx_ovrn_o <= 1'b0;
    else if (ovf)           tx_ovrn_o <= 1'b1;
    else if (tx_clr_ovrn_i) tx_ovrn_o <= 1'b0;
  end

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (reg_wdata_i),
    .rdata (head),
    .lvl   (tx_lvl_o),
    .empty (tx_empty_o),
    .full  (tx_full_o)
  );

  uart_tx_engine #(
    .OSR (OSR)
  ) u_tx_engine (
    .clk   (clk_i),
    .rst_n (rst_n),
    .tick  (osr_tick_i),
    .en    (tx_en_i),
    .empty (tx_empty_o),
    .head  (head),
    .pop   (pop),
    .line  (tx_data_o),
    .busy  (tx_busy_o)
  );

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line monitor decodes
// frames and checks them against a byte queue.
module tb_uart_tx;

  localparam int DEPTH   = 16;
  localparam int OSR     = 16;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = OSR * TDIV;
  localparam int HALF    = BIT_CLK / 2;
  localparam int STOP_AT = HALF + 9 * BIT_CLK;
  localparam logic [4:0] TX_ADDR = 5'h04;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       osr_tick_i = 1'b0;
  logic       tx_en_i = 1'b0;
  logic       tx_clr_ovrn_i = 1'b0;
  logic       reg_wen_i = 1'b0;
  logic [4:0] reg_waddr_i = '0;
  logic [7:0] reg_wdata_i = '0;
  logic       tx_data_o;
  logic       tx_busy_o;
  logic       tx_ovrn_o;
  logic [4:0] tx_lvl_o;
  logic       tx_empty_o;
  logic       tx_full_o;

  int checks = 0;
  int failures = 0;
  int frames = 0;
  logic [7:0] sb[$];

  uart_tx #(
    .DEPTH (DEPTH),
    .OSR   (OSR)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .osr_tick_i    (osr_tick_i),
    .tx_en_i       (tx_en_i),
    .tx_clr_ovrn_i (tx_clr_ovrn_i),
    .reg_wen_i     (reg_wen_i),
    .reg_waddr_i   (reg_waddr_i),
    .reg_wdata_i   (reg_wdata_i),
    .tx_data_o     (tx_data_o),
    .tx_busy_o     (tx_busy_o),
    .tx_ovrn_o     (tx_ovrn_o),
    .tx_lvl_o      (tx_lvl_o),
    .tx_empty_o    (tx_empty_o),
    .tx_full_o     (tx_full_o)
  );

  always #5 clk = ~clk;

  logic [1:0] tph = '0;
  always @(negedge clk) begin
    tph = tph + 2'd1;
    osr_tick_i = (tph == 2'd0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples each bit at its centre.
  bit         mon_on = 1'b0;
  int         mcnt = 0;
  logic [7:0] rx = '0;
  always @(negedge clk) begin
    if (!reset_i) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx_data_o === 1'b0) begin
        mon_on = 1'b1;
        mcnt = 1;
      end
    end else begin
      mcnt++;
      if (mcnt == HALF) begin
        chk("start_bit", tx_data_o, 1'b0);
      end else if (mcnt > HALF && mcnt < STOP_AT &&
                   (mcnt - HALF) % BIT_CLK == 0) begin
        rx = {tx_data_o, rx[7:1]};
      end else if (mcnt == STOP_AT) begin
        chk("stop_bit", tx_data_o, 1'b1);
        if (sb.size() == 0)
          chk("rx_unexpected", {24'd0, rx}, 32'h100);
        else
          chk("rx_byte", rx, sb.pop_front());
        frames++;
        mon_on = 1'b0;
      end
    end
  end

  task automatic write(input logic [4:0] a,
                       input logic [7:0] d);
    reg_wen_i = 1'b1;
    reg_waddr_i = a;
    reg_wdata_i = d;
    @(negedge clk);
    reg_wen_i = 1'b0;
  endtask

  task automatic drain(input string tag,
                       input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy_o || mon_on) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < budget, 1'b1);
  endtask

  initial begin
    int f0;
    int n;
    int lows;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line", tx_data_o, 1'b1);
    chk("rst_busy", tx_busy_o, 1'b0);
    chk("rst_ovrn", tx_ovrn_o, 1'b0);
    chk("rst_lvl", tx_lvl_o, 0);
    chk("rst_empty", tx_empty_o, 1'b1);
    chk("rst_full", tx_full_o, 1'b0);
    reset_i = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single frame
    tx_en_i = 1'b1;
    sb.push_back(8'hA5);
    write(TX_ADDR, 8'hA5);
    chk("t1_lvl_push", tx_lvl_o, 1);
    @(negedge clk);
    chk("t1_lvl_pop", tx_lvl_o, 0);
    chk("t1_busy", tx_busy_o, 1'b1);
    chk("t1_start", tx_data_o, 1'b0);
    drain("t1_drain", 1000);
    chk("t1_busy_end", tx_busy_o, 1'b0);
    chk("t1_idle_line", tx_data_o, 1'b1);

    // 2: back-to-back frames
    f0 = frames;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(8'(i));
      write(TX_ADDR, 8'(i));
    end
    chk("t2_lvl", tx_lvl_o, 2);
    n = 0;
    while (tx_busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t2_b2b_frames", frames - f0, 3);
    chk("t2_lvl_end", tx_lvl_o, 0);
    drain("t2_drain", 200);

    // 3: fill, overrun, clear
    tx_en_i = 1'b0;
    write(5'h05, 8'h11);
    chk("t3_other_addr", tx_lvl_o, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      sb.push_back(8'(i));
      write(TX_ADDR, 8'(i));
    end
    chk("t3_lvl_full", tx_lvl_o, DEPTH);
    chk("t3_full", tx_full_o, 1'b1);
    chk("t3_ovrn_pre", tx_ovrn_o, 1'b0);
    write(TX_ADDR, 8'd17);
    chk("t3_ovrn_set", tx_ovrn_o, 1'b1);
    chk("t3_lvl_ovf", tx_lvl_o, DEPTH);
    tx_clr_ovrn_i = 1'b1;
    @(negedge clk);
    tx_clr_ovrn_i = 1'b0;
    chk("t3_ovrn_clr", tx_ovrn_o, 1'b0);
    tx_clr_ovrn_i = 1'b1;
    write(TX_ADDR, 8'hEE);
    tx_clr_ovrn_i = 1'b0;
    chk("t3_set_wins", tx_ovrn_o, 1'b1);
    tx_clr_ovrn_i = 1'b1;
    @(negedge clk);
    tx_clr_ovrn_i = 1'b0;
    chk("t3_ovrn_clr2", tx_ovrn_o, 1'b0);

    // 4: push to full FIFO on the pop cycle
    tx_en_i = 1'b1;
    sb.push_back(8'h99);
    write(TX_ADDR, 8'h99);
    chk("t4_lvl", tx_lvl_o, DEPTH);
    chk("t4_full", tx_full_o, 1'b1);
    chk("t4_no_ovrn", tx_ovrn_o, 1'b0);
    chk("t4_busy", tx_busy_o, 1'b1);
    drain("t4_drain", 17 * 10 * BIT_CLK + 1000);
    chk("t4_lvl_end", tx_lvl_o, 0);

    // 5: disable mid-frame
    sb.push_back(8'h3C);
    write(TX_ADDR, 8'h3C);
    sb.push_back(8'hC3);
    write(TX_ADDR, 8'hC3);
    repeat (200) @(negedge clk);
    tx_en_i = 1'b0;
    n = 0;
    while (tx_busy_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_frame_done", n < 1000, 1'b1);
    repeat (12 * BIT_CLK) @(negedge clk);
    chk("t5_busy", tx_busy_o, 1'b0);
    chk("t5_line", tx_data_o, 1'b1);
    chk("t5_lvl", tx_lvl_o, 1);
    chk("t5_pending", sb.size(), 1);
    tx_en_i = 1'b1;
    drain("t5_drain", 1000);
    chk("t5_lvl_end", tx_lvl_o, 0);

    // 6: reset mid-frame
    sb.push_back(8'h5A);
    write(TX_ADDR, 8'h5A);
    sb.push_back(8'h77);
    write(TX_ADDR, 8'h77);
    repeat (300) @(negedge clk);
    #2 reset_i = 1'b0;
    #1;
    chk("t6_line", tx_data_o, 1'b1);
    chk("t6_busy", tx_busy_o, 1'b0);
    chk("t6_lvl", tx_lvl_o, 0);
    chk("t6_empty", tx_empty_o, 1'b1);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    lows = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx_data_o !== 1'b1) lows++;
    end
    chk("t6_no_residual", lows, 0);
    chk("t6_busy_after", tx_busy_o, 1'b0);
    chk("t6_lvl_after", tx_lvl_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
